// File: rtl/tempsens_pkg.sv
// Shared definitions for the temperature-sensor readout path.
// Holds the readout FSM state encoding and the default widths shared with
// tempsens_ctrl, so both sides of the result interface agree.
package tempsens_pkg;

  // Default width of the controller result (tempsens_final) and of the average
  localparam int N_TEMP_DEF = 20;
  // Default DAC width used by tempsens_ctrl
  localparam int N_VDAC_DEF = 6;
  // Result width seen on the controller's result interface
  localparam int RES_W_DEF  = N_TEMP_DEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4,
    ST_TX    = 3'd5
  } state_t;

endpackage

// File: rtl/tempsens_readout_ser.sv
// tempsens_ser: parallel-load shift transmitter, MSB first.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_load      1-cycle load strobe; frame starts the following cycle
//   i_data      N_TEMP-bit word to send
//   o_sdo       serial data (0 outside the frame)
//   o_frame     high for exactly N_TEMP cycles while o_sdo is valid
//   o_last      high during the final bit of the frame
module tempsens_ser #(
  parameter int N_TEMP = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [N_TEMP-1:0] i_data,
  output logic              o_sdo,
  output logic              o_frame,
  output logic              o_last
);

  localparam int CNT_W = $clog2(N_TEMP + 1);

  logic [N_TEMP-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= CNT_W'(N_TEMP);
    end else if (r_cnt != '0) begin
      r_sh  <= {r_sh[N_TEMP-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Remaining-bit count doubles as the frame flag; data is gated so the
  // line idles low outside the frame.
  assign o_frame = (r_cnt != '0);
  assign o_sdo   = o_frame & r_sh[N_TEMP-1];
  assign o_last  = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/tempsens_readout.sv
// tempsens_readout: consumer of tempsens_ctrl's result interface.
// Restarts the controller by pulsing o_ts_reset, waits for i_done, accumulates
// 2**N_AVG results, publishes the mean on o_avg and as a serial frame.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_ena        level: free-running batches while high
//   i_start      1-cycle pulse: run one batch (ignored while busy)
//   i_res        controller result
//   i_done       controller finished (level)
//   o_ts_reset   active-high reset to tempsens_ctrl
//   o_avg        last batch average, o_avg_valid pulses when it updates
//   o_err        sticky timeout flag, cleared by the next good batch
//   o_busy       FSM not in IDLE
//   o_sdo        serial average, MSB first, qualified by o_sd_frame
module tempsens_readout
  import tempsens_pkg::*;
#(
  parameter int N_TEMP    = N_TEMP_DEF,
  parameter int N_AVG     = 2,
  parameter int TIMEOUT_W = 22,
  parameter int RST_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ena,
  input  logic              i_start,
  input  logic [N_TEMP-1:0] i_res,
  input  logic              i_done,
  output logic              o_ts_reset,
  output logic [N_TEMP-1:0] o_avg,
  output logic              o_avg_valid,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_sdo,
  output logic              o_sd_frame
);

  localparam int ACC_W = N_TEMP + N_AVG;
  localparam int SMP_W = (N_AVG < 1) ? 1 : N_AVG;
  localparam int RST_W = $clog2(RST_CYC + 1);
  // Counter value in the last allowed WAIT cycle: the edge that ends it
  // would bring the count to 2**TIMEOUT_W-1.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [SMP_W-1:0]   r_smp;
  logic [RST_W-1:0]   r_rst_cnt;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic [N_TEMP-1:0]  r_avg;
  logic               r_avg_valid;
  logic               r_err;
  logic               w_done_ok;
  logic               w_tmo_hit;
  logic               w_ser_load;
  logic               w_ser_last;
  logic [N_TEMP-1:0]  w_mean;

  // The first WAIT cycle always has r_tmo == 0, which masks a stale done.
  assign w_done_ok  = (r_state == ST_WAIT) && (r_tmo != '0) && i_done;
  assign w_tmo_hit  = (r_state == ST_WAIT) && !w_done_ok && (r_tmo == TMO_LAST);
  assign w_ser_load = (r_state == ST_DONE);
  assign w_mean     = r_acc[ACC_W-1:N_AVG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start || i_ena) w_next = ST_START;
      ST_START: if (r_rst_cnt == RST_W'(RST_CYC - 1)) w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done_ok)      w_next = ST_ACCUM;
        else if (w_tmo_hit) w_next = ST_IDLE;
      end
      ST_ACCUM: w_next = (r_smp == {SMP_W{1'b1}}) ? ST_DONE : ST_START;
      ST_DONE:  w_next = ST_TX;
      ST_TX:    if (w_ser_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_smp       <= '0;
      r_rst_cnt   <= '0;
      r_tmo       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Per-state counters restart whenever their state is left.
      r_rst_cnt   <= (r_state == ST_START) ? r_rst_cnt + 1'b1 : '0;
      r_tmo       <= (r_state == ST_WAIT)  ? r_tmo + 1'b1     : '0;
      r_avg_valid <= (r_state == ST_DONE);
      if (r_state == ST_IDLE) begin
        r_acc <= '0;
        r_smp <= '0;
      end
      if (r_state == ST_ACCUM) begin
        r_acc <= r_acc + ACC_W'(i_res);
        r_smp <= r_smp + 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_avg <= w_mean;
        r_err <= 1'b0;
      end
      if (w_tmo_hit) r_err <= 1'b1;
    end
  end

  tempsens_ser #(
    .N_TEMP (N_TEMP)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ser_load),
    .i_data  (w_mean),
    .o_sdo   (o_sdo),
    .o_frame (o_sd_frame),
    .o_last  (w_ser_last)
  );

  assign o_ts_reset  = (r_state == ST_IDLE) || (r_state == ST_START);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_avg       = r_avg;
  assign o_avg_valid = r_avg_valid;
  assign o_err       = r_err;

endmodule
